// File: rtl/spi_tx_sequencer.sv
// SPI transmit sequencer: pops words from a first-word-fall-through TX FIFO
// and shifts them out MSB first (CPHA=0), chaining frames back-to-back while
// data is available, with a programmable SCK half-period.
module spi_tx_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              cpol,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              fifo_tx_empty,
  input  logic [DATA_W-1:0] fifo_tx_data_out,
  output logic              fifo_tx_read,
  output logic              SCK,
  output logic              MOSI,
  output logic              CS_N,
  output logic              busy,
  output logic              done
);

  // Toggle counter must reach 2*DATA_W (final half-period marker).
  localparam int unsigned TOG_W = $clog2(2 * DATA_W + 1);
  localparam logic [TOG_W-1:0] TOG_END  = TOG_W'(2 * DATA_W);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  cnt, cnt_nxt;
  logic [TOG_W-1:0]  tog, tog_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [DIV_W-1:0]  div_l, div_nxt;
  logic              cpol_l, cpol_nxt;
  logic              first, first_nxt;
  logic              read_nxt;
  logic              sck_nxt;
  logic              mosi_nxt;
  logic              cs_n_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              cont_c;

  // Another frame can start only when enabled and the FIFO has a word.
  assign cont_c = en & ~fifo_tx_empty;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tog_nxt   = tog;
    shreg_nxt = shreg;
    div_nxt   = div_l;
    cpol_nxt  = cpol_l;
    first_nxt = first;
    read_nxt  = 1'b0;
    sck_nxt   = SCK;
    mosi_nxt  = MOSI;
    cs_n_nxt  = CS_N;
    done_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        sck_nxt  = cpol;
        cs_n_nxt = 1'b1;
        mosi_nxt = 1'b0;
        cnt_nxt  = '0;
        tog_nxt  = '0;
        if (cont_c) begin
          state_nxt = LOAD;
          read_nxt  = 1'b1;
          cs_n_nxt  = 1'b0;
          first_nxt = 1'b1;
        end
      end

      LOAD: begin
        shreg_nxt = fifo_tx_data_out;
        first_nxt = 1'b0;
        if (first) begin
          // Burst start: freeze divider and polarity for the whole burst.
          div_nxt   = clk_div;
          cpol_nxt  = cpol;
          cnt_nxt   = clk_div;
          sck_nxt   = cpol;
          mosi_nxt  = fifo_tx_data_out[DATA_W-1];
          tog_nxt   = '0;
          state_nxt = SETUP;
        end else begin
          // Chained frame: LOAD closed the gap half-period, so lead now.
          cnt_nxt   = div_l;
          sck_nxt   = ~SCK;
          tog_nxt   = TOG_W'(1);
          state_nxt = SHIFT;
        end
      end

      SETUP: begin
        if (cnt == '0) begin
          cnt_nxt   = div_l;
          sck_nxt   = ~SCK;
          tog_nxt   = TOG_W'(1);
          state_nxt = SHIFT;
        end else begin
          cnt_nxt = cnt - DIV_W'(1);
        end
      end

      SHIFT: begin
        if (tog == TOG_END) begin
          // Half-period after the last trailing edge; LOAD takes its last cycle.
          if (cnt == '0) begin
            state_nxt = HOLD;
            cnt_nxt   = div_l;
          end else if (cnt == DIV_W'(1) && cont_c) begin
            state_nxt = LOAD;
            read_nxt  = 1'b1;
            cnt_nxt   = '0;
            mosi_nxt  = fifo_tx_data_out[DATA_W-1];
          end else begin
            cnt_nxt = cnt - DIV_W'(1);
          end
        end else if (cnt == '0) begin
          sck_nxt = ~SCK;
          tog_nxt = tog + TOG_W'(1);
          cnt_nxt = div_l;
          if (tog[0]) begin
            // Trailing edge: advance to the next bit.
            shreg_nxt = shreg << 1;
            if (tog != TOG_LAST) begin
              mosi_nxt = shreg[DATA_W-2];
            end else if (div_l == '0 && cont_c) begin
              // One-cycle half-period: the gap cycle itself is the LOAD.
              state_nxt = LOAD;
              read_nxt  = 1'b1;
              mosi_nxt  = fifo_tx_data_out[DATA_W-1];
            end
          end
        end else begin
          cnt_nxt = cnt - DIV_W'(1);
        end
      end

      HOLD: begin
        sck_nxt = cpol_l;
        if (cnt == '0) begin
          state_nxt = IDLE;
          cs_n_nxt  = 1'b1;
          done_nxt  = 1'b1;
          sck_nxt   = cpol;
          mosi_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - DIV_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      cnt          <= '0;
      tog          <= '0;
      shreg        <= '0;
      div_l        <= '0;
      cpol_l       <= 1'b0;
      first        <= 1'b0;
      fifo_tx_read <= 1'b0;
      SCK          <= 1'b0;
      MOSI         <= 1'b0;
      CS_N         <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      tog          <= tog_nxt;
      shreg        <= shreg_nxt;
      div_l        <= div_nxt;
      cpol_l       <= cpol_nxt;
      first        <= first_nxt;
      fifo_tx_read <= read_nxt;
      SCK          <= sck_nxt;
      MOSI         <= mosi_nxt;
      CS_N         <= cs_n_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Scoreboard bench for spi_tx_sequencer: a FIFO model feeds words, a serial
// monitor rebuilds frames, SCK half-periods and CS_N low time and checks them
// against expectations queued by the stimulus.
module tb_spi_tx_sequencer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 8;
  localparam int          BUDGET = 2000;

  logic              CLK;
  logic              RST;
  logic              en;
  logic              cpol;
  logic [DIV_W-1:0]  clk_div;
  logic              fifo_tx_empty;
  logic [DATA_W-1:0] fifo_tx_data_out;
  logic              fifo_tx_read;
  logic              SCK;
  logic              MOSI;
  logic              CS_N;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_frames[$];
  int                exp_cslow[$];

  int   pop_cnt  = 0;
  int   done_cnt = 0;
  int   mon_bits = 0;
  logic mon_cpol = 1'b0;
  int   exp_half = 1;

  // FIFO model state
  logic              f_rd;
  logic              f_prev_rd = 1'b0;
  logic [DATA_W-1:0] f_tmp;

  // Monitor state
  int                m_since   = 0;
  bit                m_have    = 1'b0;
  logic              m_prv_sck = 1'b0;
  logic              m_prv_cs  = 1'b1;
  int                m_low     = 0;
  logic [DATA_W-1:0] m_sh      = '0;
  logic [DATA_W-1:0] m_exp_b;

  int d0;
  int p0;
  int v_rd;
  int v_cs;
  int v_busy;

  spi_tx_sequencer #(
    .DATA_W(DATA_W),
    .DIV_W (DIV_W)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .en              (en),
    .cpol            (cpol),
    .clk_div         (clk_div),
    .fifo_tx_empty   (fifo_tx_empty),
    .fifo_tx_data_out(fifo_tx_data_out),
    .fifo_tx_read    (fifo_tx_read),
    .SCK             (SCK),
    .MOSI            (MOSI),
    .CS_N            (CS_N),
    .busy            (busy),
    .done            (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // FIFO model: sample the pop strobe mid-cycle, retire the word after the edge.
  initial begin
    fifo_tx_empty    = 1'b1;
    fifo_tx_data_out = '0;
    forever begin
      @(negedge CLK);
      f_rd = fifo_tx_read;
      if (f_rd && !RST) begin
        chk("pop_while_empty", int'(fifo_tx_empty), 0);
        chk("pop_consecutive", int'(f_prev_rd), 0);
      end
      f_prev_rd = f_rd;
      @(posedge CLK);
      #1;
      if (f_rd && fifo_q.size() > 0) begin
        f_tmp = fifo_q.pop_front();
        pop_cnt++;
      end
      fifo_tx_empty    = (fifo_q.size() == 0);
      fifo_tx_data_out = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end
  end

  // Done pulse counter.
  initial begin
    forever begin
      @(negedge CLK);
      if (done) done_cnt++;
    end
  end

  // Serial monitor: rebuild frames on leading edges, time SCK and CS_N.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        mon_bits  = 0;
        m_since   = 0;
        m_have    = 1'b0;
        m_low     = 0;
        m_prv_cs  = 1'b1;
        m_prv_sck = SCK;
      end else begin
        if (!CS_N) begin
          m_low++;
          m_since++;
          if (SCK != m_prv_sck) begin
            if (m_have) chk("sck_half_period", m_since, exp_half);
            m_have  = 1'b1;
            m_since = 0;
            if (SCK != mon_cpol) begin
              m_sh = {m_sh[DATA_W-2:0], MOSI};
              mon_bits++;
              if (mon_bits == DATA_W) begin
                if (exp_frames.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame actual=0x%02h expected=none", m_sh);
                end else begin
                  m_exp_b = exp_frames.pop_front();
                  chk("frame_data", int'(m_sh), int'(m_exp_b));
                end
                mon_bits = 0;
              end
            end
          end
        end else if (!m_prv_cs) begin
          chk("frame_partial_bits", mon_bits, 0);
          if (exp_cslow.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cs_burst actual=%0d expected=none", m_low);
          end else begin
            chk("cs_low_cycles", m_low, exp_cslow.pop_front());
          end
          m_low    = 0;
          m_have   = 1'b0;
          m_since  = 0;
          mon_bits = 0;
        end
        m_prv_cs  = CS_N;
        m_prv_sck = SCK;
      end
    end
  end

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_cnt;
    n     = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (done_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done expected=done within %0d cycles", budget);
    end
  endtask

  task automatic wait_bits(input int nbits, input int budget);
    int n;
    n = 0;
    while (mon_bits < nbits && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (mon_bits < nbits) begin
      checks++;
      errors++;
      $display("FAIL bits_timeout actual=%0d expected=%0d", mon_bits, nbits);
    end
  endtask

  // Directed stimulus.
  initial begin
    RST     = 1'b1;
    en      = 1'b0;
    cpol    = 1'b0;
    clk_div = '0;
    repeat (3) @(negedge CLK);
    chk("rst_cs_n", int'(CS_N), 1);
    chk("rst_sck", int'(SCK), 0);
    chk("rst_mosi", int'(MOSI), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_read", int'(fifo_tx_read), 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Single 0xA5 frame at CLK/2.
    d0 = done_cnt; p0 = pop_cnt;
    mon_cpol = 1'b0; exp_half = 1;
    exp_frames.push_back(8'hA5);
    exp_cslow.push_back(19);
    fifo_q.push_back(8'hA5);
    en = 1'b1;
    wait_done(BUDGET);
    repeat (3) @(negedge CLK);
    chk("a5_pops", pop_cnt - p0, 1);
    chk("a5_done", done_cnt - d0, 1);
    chk("a5_busy_after", int'(busy), 0);
    chk("a5_cs_after", int'(CS_N), 1);

    // Two chained frames, cpol=1, half-period 4.
    d0 = done_cnt; p0 = pop_cnt;
    cpol = 1'b1; clk_div = 8'd3;
    mon_cpol = 1'b1; exp_half = 4;
    exp_frames.push_back(8'h3C);
    exp_frames.push_back(8'hC3);
    exp_cslow.push_back(137);
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'hC3);
    wait_done(BUDGET);
    repeat (3) @(negedge CLK);
    chk("b2b_pops", pop_cnt - p0, 2);
    chk("b2b_done", done_cnt - d0, 1);
    chk("b2b_sck_idle_high", int'(SCK), 1);

    // en dropped during first frame: 0x00 must stay queued.
    d0 = done_cnt; p0 = pop_cnt;
    cpol = 1'b0; clk_div = 8'd1;
    mon_cpol = 1'b0; exp_half = 2;
    exp_frames.push_back(8'hFF);
    exp_cslow.push_back(37);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h00);
    wait_bits(2, BUDGET);
    en = 1'b0;
    wait_done(BUDGET);
    repeat (3) @(negedge CLK);
    chk("endrop_pops", pop_cnt - p0, 1);
    chk("endrop_done", done_cnt - d0, 1);
    chk("endrop_fifo_left", fifo_q.size(), 1);
    chk("endrop_fifo_head", (fifo_q.size() > 0) ? int'(fifo_q[0]) : -1, 0);
    fifo_q.delete();
    repeat (3) @(negedge CLK);

    // clk_div changed mid-frame: current frame keeps 2, next burst uses 6.
    d0 = done_cnt;
    exp_half = 2;
    exp_frames.push_back(8'h3C);
    exp_cslow.push_back(37);
    fifo_q.push_back(8'h3C);
    en = 1'b1;
    wait_bits(3, BUDGET);
    clk_div = 8'd5;
    wait_done(BUDGET);
    repeat (3) @(negedge CLK);
    exp_half = 6;
    exp_frames.push_back(8'hC3);
    exp_cslow.push_back(109);
    fifo_q.push_back(8'hC3);
    wait_done(BUDGET);
    repeat (3) @(negedge CLK);
    chk("div_change_done", done_cnt - d0, 2);

    // Reset mid-frame at bit 4 of 0x81, then a clean frame.
    cpol = 1'b1; clk_div = 8'd2;
    mon_cpol = 1'b1; exp_half = 3;
    exp_frames.push_back(8'h81);
    fifo_q.push_back(8'h81);
    wait_bits(4, BUDGET);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_cs_n", int'(CS_N), 1);
    chk("async_rst_sck", int'(SCK), 0);
    chk("async_rst_busy", int'(busy), 0);
    exp_frames.delete();
    d0 = done_cnt; p0 = pop_cnt;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    chk("rst_abort_no_done", done_cnt - d0, 0);
    chk("rst_abort_no_pop", pop_cnt - p0, 0);
    chk("rst_abort_busy", int'(busy), 0);
    d0 = done_cnt;
    exp_frames.push_back(8'h5A);
    exp_cslow.push_back(55);
    fifo_q.push_back(8'h5A);
    wait_done(BUDGET);
    repeat (3) @(negedge CLK);
    chk("post_rst_done", done_cnt - d0, 1);
    chk("post_rst_pops", pop_cnt - p0, 1);

    // Enabled with an empty FIFO: nothing may happen.
    v_rd = 0; v_cs = 0; v_busy = 0;
    p0 = pop_cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (fifo_tx_read) v_rd++;
      if (!CS_N) v_cs++;
      if (busy) v_busy++;
    end
    chk("empty_read_cycles", v_rd, 0);
    chk("empty_cs_low_cycles", v_cs, 0);
    chk("empty_busy_cycles", v_busy, 0);
    chk("empty_pops", pop_cnt - p0, 0);

    chk("frames_outstanding", exp_frames.size(), 0);
    chk("cs_bursts_outstanding", exp_cslow.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit in case a wait loop is bypassed.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
